// File: rtl/count_seq_pkg.sv
// Shared types and field encodings for the count sequencer.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  localparam logic DIR_UP        = 1'b0;
  localparam logic DIR_DOWN      = 1'b1;

endpackage

// File: rtl/count_sequencer_prescale_tick.sv
// Prescale counter: counts 0..period and strobes term_o on the last count.
// load_i captures a new period and restarts; clear_i restarts without reloading.
module prescale_tick #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [PRESCALE_W-1:0] period_i,
  input  logic                  clear_i,
  input  logic                  en_i,
  output logic                  term_o
);

  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign term_o = (cnt_q == period_q);

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      period_d = period_i;
      cnt_d    = '0;
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = term_o ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Programmable up/down count sequencer with start/busy/done handshake,
// one-shot or periodic operation, pause and abort.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  PAUSE,
  input  logic                  MODE,
  input  logic                  DIR,
  input  logic [WIDTH-1:0]      LIMIT,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic [WIDTH-1:0]      QOUT,
  output logic                  BUSY,
  output logic                  TICK,
  output logic                  DONE,
  output logic                  WRAP
);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;

  logic busy;
  logic start_acc;
  logic abort;
  logic adv;
  logic pre_term;
  logic step;
  logic at_term;
  logic oneshot_end;

  assign start_acc = (state_q == IDLE) && START && !STOP;
  assign abort     = busy && STOP;

  // A due step in RUN wins over PAUSE; otherwise PAUSE freezes the prescaler
  // for exactly the cycles it is high, including the HOLD->RUN edge counting.
  assign adv = !STOP && (((state_q == RUN) && (!PAUSE || pre_term)) ||
                         ((state_q == HOLD) && !PAUSE));
  assign step        = adv && pre_term;
  assign at_term     = (dir_q == DIR_DOWN) ? (qout_q == '0) : (qout_q == limit_q);
  assign oneshot_end = step && at_term && (mode_q == MODE_ONESHOT);

  prescale_tick #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescale (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .load_i   (start_acc),
    .period_i (PRESCALE),
    .clear_i  (abort),
    .en_i     (adv),
    .term_o   (pre_term)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_acc) state_d = RUN;
      RUN, HOLD: begin
        if (STOP)             state_d = IDLE;
        else if (oneshot_end) state_d = IDLE;
        else if (PAUSE)       state_d = HOLD;
        else                  state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN) || (state_q == HOLD);
  end

  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q;
    limit_d = limit_q;
    qout_d  = qout_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    if (start_acc) begin
      mode_d  = MODE;
      dir_d   = DIR;
      limit_d = LIMIT;
      qout_d  = (DIR == DIR_DOWN) ? LIMIT : '0;
    end else if (step) begin
      tick_d = 1'b1;
      if (!at_term) begin
        qout_d = (dir_q == DIR_DOWN) ? qout_q - WIDTH'(1) : qout_q + WIDTH'(1);
      end else if (mode_q == MODE_ONESHOT) begin
        done_d = 1'b1;
      end else begin
        qout_d = (dir_q == DIR_DOWN) ? limit_q : '0;
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
      limit_q <= '0;
      qout_q  <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      limit_q <= limit_d;
      qout_q  <= qout_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign QOUT = qout_q;
  assign BUSY = busy;
  assign TICK = tick_q;
  assign DONE = done_q;
  assign WRAP = wrap_q;

endmodule
